// File: rtl/output_weight_update.sv
// Output-layer weight update: bit-serial gradient products for both output weights,
// followed by a learning-rate shift and a saturating subtract into the live weights.
module output_weight_update #(
  parameter int unsigned XW       = 10,
  parameter int unsigned EW       = 21,
  parameter int unsigned WW       = 8,
  parameter int unsigned LR_SHIFT = 8,
  parameter int          W0_INIT  = 5,
  parameter int          W1_INIT  = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [EW-1:0] err_i,
  input  logic [XW-1:0] x0_i,
  input  logic [XW-1:0] x1_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [WW-1:0] w0_o,
  output logic [WW-1:0] w1_o
);

  localparam int unsigned PW = EW + XW;
  localparam int unsigned DW = PW + 1;
  localparam int unsigned CW = (XW > 1) ? $clog2(XW) : 1;

  localparam logic signed [DW-1:0] WMax = DW'((1 << (WW - 1)) - 1);
  localparam logic signed [DW-1:0] WMin = -WMax - DW'(1);

  typedef enum logic [1:0] {StIdle, StMul0, StMul1, StApply} state_e;

  state_e        state_q, state_d;
  logic [EW-1:0] err_q, err_d;
  logic [XW-1:0] x0_q, x0_d;
  logic [XW-1:0] x1_q, x1_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] p0_q, p0_d;
  logic [PW-1:0] p1_q, p1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] w0_q, w0_d;
  logic [WW-1:0] w1_q, w1_d;
  logic          done_q, done_d;

  logic [PW-1:0] err_ext;
  logic [PW-1:0] term;
  logic [PW-1:0] acc_nxt;
  logic [XW-1:0] x_sel;
  logic          last_bit;

  // Full-width subtract of the floored step, clamped to the signed weight range.
  function automatic logic [WW-1:0] sat_sub(input logic [WW-1:0] w, input logic [PW-1:0] p);
    logic signed [DW-1:0] p_ext;
    logic signed [DW-1:0] step;
    logic signed [DW-1:0] w_ext;
    logic signed [DW-1:0] diff;
    p_ext = {p[PW-1], p};
    step  = p_ext >>> LR_SHIFT;
    w_ext = {{(DW - WW){w[WW-1]}}, w};
    diff  = w_ext - step;
    if (diff > WMax) begin
      sat_sub = WMax[WW-1:0];
    end else if (diff < WMin) begin
      sat_sub = WMin[WW-1:0];
    end else begin
      sat_sub = diff[WW-1:0];
    end
  endfunction

  always_comb begin
    err_ext  = {{XW{err_q[EW-1]}}, err_q};
    term     = err_ext << cnt_q;
    x_sel    = (state_q == StMul0) ? x0_q : x1_q;
    acc_nxt  = x_sel[cnt_q] ? (acc_q + term) : acc_q;
    last_bit = (cnt_q == CW'(XW - 1));
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    acc_d   = acc_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    cnt_d   = cnt_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    done_d  = done_q;
    if (en_i) begin
      done_d = 1'b0;
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            err_d   = err_i;
            x0_d    = x0_i;
            x1_d    = x1_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StMul0;
          end
        end
        StMul0, StMul1: begin
          if (last_bit) begin
            if (state_q == StMul0) begin
              p0_d    = acc_nxt;
              state_d = StMul1;
            end else begin
              p1_d    = acc_nxt;
              state_d = StApply;
            end
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + CW'(1);
          end
        end
        StApply: begin
          w0_d    = sat_sub(w0_q, p0_q);
          w1_d    = sat_sub(w1_q, p1_q);
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      err_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      acc_q   <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      cnt_q   <= '0;
      w0_q    <= WW'(W0_INIT);
      w1_q    <= WW'(W1_INIT);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      acc_q   <= acc_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      cnt_q   <= cnt_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign w0_o   = w0_q;
  assign w1_o   = w1_q;

endmodule

// File: tb/tb_output_weight_update.sv
// Scoreboard bench for output_weight_update: directed vectors push expected weights,
// a negedge monitor pops and compares them whenever done_o pulses.
module tb_output_weight_update;

  localparam int XW = 10;
  localparam int EW = 21;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          valid;
  logic [EW-1:0] err;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic          busy;
  logic          done;
  logic [WW-1:0] w0;
  logic [WW-1:0] w1;

  output_weight_update dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .valid_i(valid),
    .err_i  (err),
    .x0_i   (x0),
    .x1_i   (x1),
    .busy_o (busy),
    .done_o (done),
    .w0_o   (w0),
    .w1_o   (w1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w0;
    int w1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("done_has_expectation", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("w0_after_done", int'($signed(w0)), mon_e.w0);
        check("w1_after_done", int'($signed(w1)), mon_e.w1);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where done_o is first seen high.
  task automatic run_op(input string name, input int e, input int a, input int b,
                        input int ew0, input int ew1, input int stall_at, input bit pulse);
    int n;
    int nb;
    exp_t x;
    x.w0 = ew0;
    x.w1 = ew1;
    sb.push_back(x);
    valid = 1'b1;
    err   = e[EW-1:0];
    x0    = a[XW-1:0];
    x1    = b[XW-1:0];
    @(negedge clk);
    valid = 1'b0;
    err   = EW'($urandom);
    x0    = XW'($urandom);
    x1    = XW'($urandom);
    n  = 0;
    nb = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) nb++;
      valid = pulse && (n == 3 || n == 12 || n == 20);
      if (n == stall_at) begin
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        n += 5;
      end
      @(negedge clk);
      n++;
    end
    valid = 1'b0;
    check({name, "_latency"}, n, (stall_at >= 0) ? 26 : 21);
    check({name, "_busy_cycles"}, nb, 21);
    check({name, "_busy_at_done"}, int'(busy), 0);
  endtask

  initial begin
    int ok;
    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b0;
    err   = '0;
    x0    = '0;
    x1    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_w0", int'($signed(w0)), 5);
    check("reset_w1", int'($signed(w1)), 8);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || w0 !== 8'd5 || w1 !== 8'd8) ok = 0;
    end
    check("idle_50_cycles", ok, 1);

    run_op("basic", 256, 1, 0, 4, 8, -1, 1'b0);
    @(negedge clk);
    do_reset();
    run_op("neg_err", -512, 2, 3, 9, 14, -1, 1'b0);
    @(negedge clk);
    do_reset();
    run_op("floor", -1, 1, 1, 6, 9, -1, 1'b0);
    @(negedge clk);
    do_reset();
    run_op("sat_neg", 1048575, 1023, 1023, -128, -128, -1, 1'b0);
    repeat (2) @(negedge clk);
    run_op("sat_pos1", -1048576, 1023, 1023, 127, 127, -1, 1'b0);
    repeat (2) @(negedge clk);
    run_op("sat_pos2", -1048576, 1023, 1023, 127, 127, -1, 1'b0);
    repeat (2) @(negedge clk);

    // Abort: reset lands on edge 10 of an update; no done may follow.
    valid = 1'b1;
    err   = EW'(256);
    x0    = XW'(1);
    x1    = XW'(0);
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_w0", int'($signed(w0)), 5);
    check("abort_w1", int'($signed(w1)), 8);
    check("abort_busy", int'(busy), 0);
    repeat (30) @(negedge clk);

    run_op("stall", -512, 2, 3, 9, 14, 15, 1'b0);
    @(negedge clk);
    do_reset();
    run_op("valid_while_busy", 256, 1, 0, 4, 8, -1, 1'b1);
    repeat (30) @(negedge clk);

    run_op("b2b_first", 256, 0, 1, 4, 7, -1, 1'b0);
    run_op("b2b_second", 256, 1, 1, 3, 6, -1, 1'b0);
    repeat (30) @(negedge clk);

    check("pending_expectations", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_weight_update.md
Name: output_weight_update

Overview:
- Downstream stage of the output neuron; closes the training loop for the output layer.
- Consumes the signed output error (final value minus target) and the two hidden-neuron activations.
- Computes a shifted gradient step for each output weight with a bit-serial multiplier, then applies it with saturation.
- Holds the live output weights, which drive the output neuron's w0_i/w1_i in place of constants.

Parameters:
- XW, 10, hidden activation width (unsigned).
- EW, 21, error width (signed, two's complement).
- WW, 8, weight width (signed).
- LR_SHIFT, 8, learning-rate divisor exponent (step = product >>> LR_SHIFT).
- W0_INIT, 5, reset value of w0_o.
- W1_INIT, 8, reset value of w1_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  clock enable; low = all registers hold, FSM stalls.
- valid_i  in  1  start request; sampled only in IDLE with en_i=1.
- err_i  in  EW  signed error sample.
- x0_i  in  XW  hidden activation 0 (unsigned).
- x1_i  in  XW  hidden activation 1 (unsigned).
- busy_o  out  1  high whenever FSM is not in IDLE (combinational from state).
- done_o  out  1  one-cycle pulse; weights updated on the same edge.
- w0_o  out  WW  current output weight 0 (signed).
- w1_o  out  WW  current output weight 1 (signed).

Behaviour:
- Reset (rst_i=1 at an edge, regardless of en_i or state):
  - state=IDLE, w0_o=W0_INIT, w1_o=W1_INIT.
  - done_o=0, accumulator=0, bit counter=0.
- States: IDLE, MUL0, MUL1, APPLY. All transitions require en_i=1; with en_i=0 every register holds and done_o holds its value.
- IDLE:
  - On valid_i=1 (edge 0): capture err_i, x0_i and x1_i into operand registers; clear accumulator and counter; go to MUL0.
  - Otherwise stay in IDLE.
- MUL0 (edges 1..XW):
  - Each edge: if bit[cnt] of captured x0 is 1, acc += sign-extended err << cnt.
  - cnt increments each edge; after bit XW-1, store acc as p0, clear acc and cnt, go to MUL1.
- MUL1 (edges XW+1..2XW): same sequence on x1; result stored as p1; go to APPLY.
- APPLY (edge 2XW+1):
  - w0_o <= sat(w0_o - (p0 >>> LR_SHIFT)).
  - w1_o <= sat(w1_o - (p1 >>> LR_SHIFT)).
  - done_o <= 1; go to IDLE.
- done_o is cleared on the next enabled edge.
- Latency: done_o rises 2*XW+1 = 21 enabled edges after the capture edge. busy_o is high for 21 cycles.
- Arithmetic:
  - Products are EW+XW = 31-bit signed, exact with no overflow (max |err|*1023 < 2^30).
  - The shift is arithmetic and rounds toward minus infinity (-1 >>> 8 = -1).
  - The subtraction is performed at full width, then saturated to [-128, +127].
- Operand isolation: err_i/x0_i/x1_i changes after capture have no effect. valid_i while busy is ignored; it is neither queued nor flagged.
- Back-to-back: valid_i high in the cycle done_o is high is accepted, because the FSM is already in IDLE.
- err=0 or x=0 gives a zero step; the weight is unchanged but done_o still pulses.
- Reset mid-operation aborts the update: weights return to init, no done_o pulse.

Test Plan:
- Reset then idle: hold rst_i 2 cycles -> w0_o=5, w1_o=8, busy_o=0, done_o=0; remain so with valid_i=0 for 50 cycles.
- Basic step: err=+256, x0=1, x1=0 -> busy_o high 21 cycles, done_o pulse at edge 21, w0_o=4, w1_o=8.
- Negative error: err=-512, x0=2, x1=3 -> p0=-1024, p1=-1536, w0_o=9, w1_o=14.
- Floor rounding: err=-1, x0=1, x1=1 -> w0_o=6, w1_o=9.
- Saturation: err=1048575, x0=1023, x1=1023 -> w0_o=-128, w1_o=-128. Then err=-1048576, x0=x1=1023 repeated twice -> both weights saturate at +127.
- Control edges:
  - valid_i pulses during busy -> exactly one done_o.
  - en_i low for 5 cycles mid-MUL1 -> done_o delayed by exactly 5 cycles, same result.
  - rst_i at edge 10 -> weights 5/8, no done_o.
  - valid_i during the done_o cycle -> second update starts immediately.
